// File: rtl/wptr_full_lvl.sv
// wptr_full_lvl: write-domain pointer and flag generator for an async FIFO.
// Keeps the binary/Gray write pointers, registered full, almost-full and
// occupancy, and drives the RAM write strobe and address.
// Optional feature: define WPTR_OVF_EN to build the sticky overflow flag
// (woverflow); without it woverflow is tied low and wovf_clr is ignored.

module wptr_full_lvl #(
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   wafull_thresh,
  input  logic                wovf_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  // Binary to reflected Gray code.
  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Gray to binary as an XOR prefix running from the MSB down.
  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] wbin_r;
  logic [ADDRSIZE:0] wptr_r;
  logic              wfull_r;
  logic              wafull_r;
  logic [ADDRSIZE:0] wlevel_r;

  logic              wen_s;
  logic [ADDRSIZE:0] wbinnext_s;
  logic [ADDRSIZE:0] wgraynext_s;
  logic [ADDRSIZE:0] wq2_rbin_s;
  logic [ADDRSIZE:0] levnext_s;
  logic [ADDRSIZE:0] full_cmp_s;
  logic              wfullnext_s;
  logic              wafullnext_s;

  // Next-pointer, level and flag computation from the current state and inputs.
  always_comb begin
    wen_s         = winc & ~wfull_r;
    wbinnext_s    = wbin_r + {{ADDRSIZE{1'b0}}, wen_s};
    wgraynext_s   = bin2gray(wbinnext_s);
    wq2_rbin_s    = gray2bin(wq2_rptr);
    levnext_s     = wbinnext_s - wq2_rbin_s;
    // Full when the write pointer is exactly one lap ahead: the top two Gray
    // bits differ from the read pointer's and the rest match.
    full_cmp_s    = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    wfullnext_s   = (wgraynext_s == full_cmp_s);
    wafullnext_s  = (levnext_s >= wafull_thresh);
  end

  // Pointer, level and flag registers; async reset clears everything at once.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_r   <= {(ADDRSIZE+1){1'b0}};
      wptr_r   <= {(ADDRSIZE+1){1'b0}};
      wfull_r  <= 1'b0;
      wafull_r <= 1'b0;
      wlevel_r <= {(ADDRSIZE+1){1'b0}};
    end else begin
      wbin_r   <= wbinnext_s;
      wptr_r   <= wgraynext_s;
      wfull_r  <= wfullnext_s;
      wafull_r <= wafullnext_s;
      wlevel_r <= levnext_s;
    end
  end

`ifdef WPTR_OVF_EN
  logic woverflow_r;

  // Sticky overflow: a blocked write sets it, wovf_clr clears it, set wins.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      woverflow_r <= 1'b0;
    end else if (winc & wfull_r) begin
      woverflow_r <= 1'b1;
    end else if (wovf_clr) begin
      woverflow_r <= 1'b0;
    end else begin
      woverflow_r <= woverflow_r;
    end
  end

  assign woverflow = woverflow_r;
`else
  logic unused_wovf_clr_s;

  assign unused_wovf_clr_s = wovf_clr;
  assign woverflow         = 1'b0;
`endif

  assign wen    = wen_s;
  assign waddr  = wbin_r[ADDRSIZE-1:0];
  assign wptr   = wptr_r;
  assign wfull  = wfull_r;
  assign wafull = wafull_r;
  assign wlevel = wlevel_r;

  wptr_full_lvl_chk #(
    .ADDRSIZE (ADDRSIZE)
  ) u_chk (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wen    (wen_s),
    .wfull  (wfull_r),
    .wptr   (wptr_r),
    .wlevel (wlevel_r)
  );

endmodule

// Property checker for the write-side pointer block.
module wptr_full_lvl_chk #(
  parameter int ADDRSIZE = 4
) (
  input logic              wclk,
  input logic              wrst_n,
  input logic              wen,
  input logic              wfull,
  input logic [ADDRSIZE:0] wptr,
  input logic [ADDRSIZE:0] wlevel
);

  localparam logic [ADDRSIZE:0] DEPTH_L = {1'b1, {ADDRSIZE{1'b0}}};

  // The Gray pointer crosses clock domains, so it may flip at most one bit.
  a_gray_step: assert property (@(posedge wclk) disable iff (!wrst_n)
    $onehot0(wptr ^ $past(wptr)));

  // Occupancy never exceeds the RAM depth.
  a_level_range: assert property (@(posedge wclk) disable iff (!wrst_n)
    wlevel <= DEPTH_L);

  // No RAM write strobe while full.
  a_wen_gate: assert property (@(posedge wclk) disable iff (!wrst_n)
    !(wen && wfull));

  // Full and a level of DEPTH describe the same condition.
  a_full_level: assert property (@(posedge wclk) disable iff (!wrst_n)
    wfull == (wlevel == DEPTH_L));

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Scoreboard bench for wptr_full_lvl: the driver keeps an occupancy model in
// terms of write/read counts and pushes expected outputs; a monitor compares.
module tb_wptr_full_lvl;

  localparam int ADDRSIZE = 4;
  localparam int DEPTH    = 1 << ADDRSIZE;
  localparam int PMOD     = 2 * DEPTH;

  logic                wclk;
  logic                wrst_n;
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE:0]   wafull_thresh;
  logic                wovf_clr;
  logic                wen;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                wafull;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  wptr_full_lvl #(.ADDRSIZE(ADDRSIZE)) dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .winc          (winc),
    .wq2_rptr      (wq2_rptr),
    .wafull_thresh (wafull_thresh),
    .wovf_clr      (wovf_clr),
    .wen           (wen),
    .waddr         (waddr),
    .wptr          (wptr),
    .wfull         (wfull),
    .wafull        (wafull),
    .wlevel        (wlevel),
    .woverflow     (woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    int wen;
    int waddr;
    int wptr;
    int wfull;
    int wafull;
    int wlevel;
    int wovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model: counts of accepted writes and of reads seen by the write side.
  int m_w     = 0;
  int m_r     = 0;
  int m_lev   = 0;
  int m_afull = 0;
  int m_ovf   = 0;

  function automatic int gray(input int n);
    return n ^ (n >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // One cycle: drive inputs at negedge, publish expectations, advance model at posedge.
  task automatic step(input logic rst_v, input logic inc_v, input logic rd_v,
                      input logic clr_v, input int thr);
    exp_t e;
    int   acc;
    int   was_full;
    @(negedge wclk);
    wrst_n        = rst_v;
    winc          = inc_v;
    wovf_clr      = clr_v;
    wafull_thresh = (ADDRSIZE+1)'(thr);
    if (!rst_v) begin
      m_w = 0; m_r = 0; m_lev = 0; m_afull = 0; m_ovf = 0;
    end else if (rd_v && (m_r < m_w)) begin
      m_r++;
    end
    wq2_rptr = (ADDRSIZE+1)'(gray(m_r % PMOD));
    was_full = (m_lev == DEPTH) ? 1 : 0;
    e.wen    = (inc_v && !was_full) ? 1 : 0;
    e.waddr  = m_w % DEPTH;
    e.wptr   = gray(m_w % PMOD);
    e.wfull  = was_full;
    e.wafull = m_afull;
    e.wlevel = m_lev;
    e.wovf   = m_ovf;
    exp_q.push_back(e);
    @(posedge wclk);
    if (rst_v) begin
      acc     = e.wen;
      m_w     = m_w + acc;
      m_lev   = m_w - m_r;
      m_afull = (m_lev >= thr) ? 1 : 0;
`ifdef WPTR_OVF_EN
      if (inc_v && was_full) m_ovf = 1;
      else if (clr_v)        m_ovf = 0;
`else
      m_ovf = 0;
`endif
    end
  endtask

  // Monitor: compare every published expectation against the DUT off the edges.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wen",       int'(wen),       e.wen);
        chk("waddr",     int'(waddr),     e.waddr);
        chk("wptr",      int'(wptr),      e.wptr);
        chk("wfull",     int'(wfull),     e.wfull);
        chk("wafull",    int'(wafull),    e.wafull);
        chk("wlevel",    int'(wlevel),    e.wlevel);
        chk("woverflow", int'(woverflow), e.wovf);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus sequence: directed corner cases, then randomized traffic.
  initial begin
    int thr;
    wrst_n = 1'b0; winc = 1'b0; wq2_rptr = '0; wafull_thresh = 5'd12; wovf_clr = 1'b0;

    // Reset with winc toggling: wen must follow winc.
    step(1'b0, 1'b0, 1'b0, 1'b0, 12);
    step(1'b0, 1'b1, 1'b0, 1'b0, 12);
    step(1'b0, 1'b0, 1'b0, 1'b0, 12);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 12);

    // Fill to full (almost-full at 12), then one write while full.
    repeat (17) step(1'b1, 1'b1, 1'b0, 1'b0, 12);
    // Overflow set and clear in the same cycle, then clear alone.
    step(1'b1, 1'b1, 1'b0, 1'b1, 12);
    step(1'b1, 1'b0, 1'b0, 1'b1, 12);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12);

    // Drain completely by Gray steps, then wrap with 16 more writes.
    repeat (16) step(1'b1, 1'b0, 1'b1, 1'b0, 12);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12);
    repeat (17) step(1'b1, 1'b1, 1'b0, 1'b0, 12);

    // Down to level 8, then simultaneous write and read.
    repeat (8) step(1'b1, 1'b0, 1'b1, 1'b0, 12);
    step(1'b1, 1'b1, 1'b1, 1'b0, 12);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12);

    // Reset mid-burst, then a write right after release.
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 12);
    step(1'b0, 1'b1, 1'b0, 1'b0, 12);
    step(1'b0, 1'b0, 1'b0, 1'b0, 12);
    step(1'b1, 1'b1, 1'b0, 1'b0, 12);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12);

    // Threshold 0: almost-full from the first edge after reset.
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    // Threshold above depth: almost-full never asserts.
    repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0, DEPTH + 1);

    // Randomized traffic with occasional threshold changes and resets.
    thr = 12;
    for (int i = 0; i < 400; i++) begin
      if ((i % 50) == 0) thr = int'($urandom_range(0, DEPTH + 1));
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) == 0),
           thr);
    end

    @(negedge wclk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
